// File: rtl/apogee_mem_pkg.sv
// ============================================================================
//  Module      : apogee_mem_pkg
//  Description : Shared types and constants for the main-RAM port A arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apogee_mem_pkg;

   localparam int RAM_ADDR_W  = 16;
   localparam int LD_BANK_MSB = 24;
   localparam int LD_BANK_LSB = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      LOAD   = 3'd2,
      CPU_WR = 3'd3,
      CPU_RD = 3'd4
   } arb_state_t;

   // Loader bytes outside bank 0 do not belong to main RAM and are discarded.
   function automatic logic ld_in_bank0(input logic [LD_BANK_MSB:0] addr);
      return (addr[LD_BANK_MSB:LD_BANK_LSB] == '0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_clear_engine.sv
// ============================================================================
//  Module      : ram_clear_engine
//  Description : Address sweep counter and busy flag for the RAM clear pass.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_clear_engine
   import apogee_mem_pkg::*;
#(
   parameter int                ADDR_W = RAM_ADDR_W,
   parameter logic [ADDR_W-1:0] LAST   = {ADDR_W{1'b1}}
)(
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              start_i,
   input  logic              advance_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] addr_o
);

   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      done_o = busy_q & advance_i & (cnt_q == LAST);
      if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = '0;
      end else if (busy_q && advance_i) begin
         if (cnt_q == LAST) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_o = busy_q;
   assign addr_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Shares main-RAM port A between clear engine, loader and CPU.
//                Optional CPU write protection window under RAM_WP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter
   import apogee_mem_pkg::*;
#(
   parameter int                ADDR_W     = RAM_ADDR_W,
   parameter logic [7:0]        CLEAR_VAL  = 8'h00,
   parameter logic [ADDR_W-1:0] CLEAR_LAST = {ADDR_W{1'b1}}
)(
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   clr_start,
   output logic                   clr_busy,
   input  logic                   ld_wr,
   input  logic [LD_BANK_MSB:0]   ld_addr,
   input  logic [7:0]             ld_din,
   output logic                   ld_wait,
   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [ADDR_W-1:0]      cpu_addr,
   input  logic [7:0]             cpu_din,
`ifdef RAM_WP_EN
   input  logic [ADDR_W-1:0]      wp_lo,
   input  logic [ADDR_W-1:0]      wp_hi,
`endif
   output logic [7:0]             cpu_dout,
   output logic                   cpu_ready,
   output logic [ADDR_W-1:0]      ram_addr,
   output logic [7:0]             ram_din,
   output logic                   ram_we,
   input  logic [7:0]             ram_dout
);

   arb_state_t        state_q, state_d;
   logic              rd_phase_q, rd_phase_d;
   logic              clr_pend_q, clr_pend_d;
   logic              ld_full_q, ld_full_d;
   logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
   logic [7:0]        ld_din_q, ld_din_d;
   logic [7:0]        cpu_dout_q, cpu_dout_d;

   logic              ld_accept;
   logic              clr_go;
   logic              clr_kick;
   logic              clr_advance;
   logic              clr_done;
   logic [ADDR_W-1:0] clr_addr;
   logic              wp_block;

   ram_clear_engine #(
      .ADDR_W (ADDR_W),
      .LAST   (CLEAR_LAST)
   ) u_clear (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .start_i   (clr_kick),
      .advance_i (clr_advance),
      .busy_o    (clr_busy),
      .done_o    (clr_done),
      .addr_o    (clr_addr)
   );

`ifdef RAM_WP_EN
   assign wp_block = (cpu_addr >= wp_lo) && (cpu_addr <= wp_hi);
`else
   assign wp_block = 1'b0;
`endif

   assign ld_accept = ld_wr & ~ld_full_q & ld_in_bank0(ld_addr);
   assign clr_go    = clr_start | clr_pend_q;
   assign ld_wait   = ld_full_q;

   // The read byte is forwarded in its completion cycle, then held.
   assign cpu_dout  = (state_q == CPU_RD && rd_phase_q) ? ram_dout : cpu_dout_q;

   always_comb begin
      ld_full_d  = ld_full_q;
      ld_addr_d  = ld_addr_q;
      ld_din_d   = ld_din_q;
      clr_pend_d = clr_pend_q;
      if (state_q == LOAD) begin
         ld_full_d = 1'b0;
      end
      if (ld_accept) begin
         ld_full_d = 1'b1;
         ld_addr_d = ld_addr[ADDR_W-1:0];
         ld_din_d  = ld_din;
      end
      if (clr_start && state_q != CLEAR) begin
         clr_pend_d = 1'b1;
      end
      if (clr_kick) begin
         clr_pend_d = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_phase_d  = 1'b0;
      clr_kick    = 1'b0;
      clr_advance = 1'b0;
      ram_addr    = '0;
      ram_din     = '0;
      ram_we      = 1'b0;
      cpu_ready   = 1'b0;
      cpu_dout_d  = cpu_dout_q;
      case (state_q)
         IDLE: begin
            if (clr_go) begin
               state_d  = CLEAR;
               clr_kick = 1'b1;
            end else if (ld_full_q || ld_accept) begin
               state_d = LOAD;
            end else if (cpu_req) begin
               state_d = cpu_we ? CPU_WR : CPU_RD;
            end
         end
         CLEAR: begin
            ram_addr    = clr_addr;
            ram_din     = CLEAR_VAL;
            ram_we      = 1'b1;
            clr_advance = 1'b1;
            if (clr_done) begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            ram_addr = ld_addr_q;
            ram_din  = ld_din_q;
            ram_we   = 1'b1;
            state_d  = IDLE;
         end
         CPU_WR: begin
            ram_addr  = cpu_addr;
            ram_din   = cpu_din;
            ram_we    = ~wp_block;
            cpu_ready = 1'b1;
            state_d   = IDLE;
         end
         CPU_RD: begin
            ram_addr = cpu_addr;
            if (!rd_phase_q) begin
               rd_phase_d = 1'b1;
            end else begin
               cpu_ready  = 1'b1;
               cpu_dout_d = ram_dout;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         rd_phase_q <= 1'b0;
         clr_pend_q <= 1'b0;
         ld_full_q  <= 1'b0;
         ld_addr_q  <= '0;
         ld_din_q   <= '0;
         cpu_dout_q <= '0;
      end else begin
         state_q    <= state_d;
         rd_phase_q <= rd_phase_d;
         clr_pend_q <= clr_pend_d;
         ld_full_q  <= ld_full_d;
         ld_addr_q  <= ld_addr_d;
         ld_din_q   <= ld_din_d;
         cpu_dout_q <= cpu_dout_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Scoreboard bench for ram_port_arbiter with a RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

   logic        clk_sys   = 1'b0;
   logic        reset     = 1'b1;
   logic        clr_start = 1'b0;
   logic        ld_wr     = 1'b0;
   logic [24:0] ld_addr   = '0;
   logic [7:0]  ld_din    = '0;
   logic        cpu_req   = 1'b0;
   logic        cpu_we    = 1'b0;
   logic [15:0] cpu_addr  = '0;
   logic [7:0]  cpu_din   = '0;
`ifdef RAM_WP_EN
   logic [15:0] wp_lo     = 16'hF000;
   logic [15:0] wp_hi     = 16'hFFFF;
`endif
   logic        clr_busy;
   logic        ld_wait;
   logic [7:0]  cpu_dout;
   logic        cpu_ready;
   logic [15:0] ram_addr;
   logic [7:0]  ram_din;
   logic        ram_we;
   logic [7:0]  ram_dout;

   ram_port_arbiter #(
      .ADDR_W     (16),
      .CLEAR_VAL  (8'h00),
      .CLEAR_LAST (16'h00FF)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .clr_start (clr_start),
      .clr_busy  (clr_busy),
      .ld_wr     (ld_wr),
      .ld_addr   (ld_addr),
      .ld_din    (ld_din),
      .ld_wait   (ld_wait),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_din   (cpu_din),
`ifdef RAM_WP_EN
      .wp_lo     (wp_lo),
      .wp_hi     (wp_hi),
`endif
      .cpu_dout  (cpu_dout),
      .cpu_ready (cpu_ready),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout)
   );

   always #5 clk_sys = ~clk_sys;

   // RAM model: unwritten locations read as addr[7:0]^8'h5A.
   logic [7:0]  mem    [0:65535];
   bit          mem_wr [0:65535];
   logic [15:0] raddr_q = '0;
   always @(posedge clk_sys) begin
      if (ram_we) begin
         mem[ram_addr]    <= ram_din;
         mem_wr[ram_addr] <= 1'b1;
      end
      raddr_q <= ram_addr;
   end
   assign ram_dout = mem_wr[raddr_q] ? mem[raddr_q] : (raddr_q[7:0] ^ 8'h5A);

   int          errors = 0;
   int          checks = 0;
   bit          mon_en = 1'b0;
   logic [23:0] wr_q  [$];
   logic [8:0]  cpu_q [$];
   realtime     t_fall, t_ready;
   int          lat, lat2, lat3, nw, n;
   bit          found;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every RAM write and every CPU completion must match the scoreboard.
   always @(negedge clk_sys) begin
      if (mon_en) begin
         if (ram_we) begin
            if (wr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ram_we: got addr 0x%0h data 0x%0h, expected no write",
                        ram_addr, ram_din);
            end else begin
               chk("ram_write", {ram_addr, ram_din}, wr_q.pop_front());
            end
         end
         if (cpu_ready) begin
            if (cpu_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_cpu_ready: got ready at addr 0x%0h, expected none", cpu_addr);
            end else begin
               logic [8:0] e;
               e = cpu_q.pop_front();
               if (e[8]) chk("cpu_rd_data", cpu_dout, e[7:0]);
               else      chk("cpu_wr_ram_we", ram_we, e[0]);
            end
         end
      end
   end

   task automatic cpu_access(input bit we, input logic [15:0] a, input logic [7:0] d,
                             input logic [7:0] exp_rd, input bit blocked, output int l);
      bit got;
      got = 1'b0;
      l   = 0;
      if (we) begin
         cpu_q.push_back({1'b0, 7'd0, ~blocked});
         if (!blocked) wr_q.push_back({a, d});
      end else begin
         cpu_q.push_back({1'b1, exp_rd});
      end
      cpu_req  = 1'b1;
      cpu_we   = we;
      cpu_addr = a;
      cpu_din  = d;
      for (int i = 1; i <= 2000 && !got; i++) begin
         @(negedge clk_sys);
         if (cpu_ready) begin
            got = 1'b1;
            l   = i;
         end
      end
      if (!got) chk("cpu_ready_timeout", 32'd0, 32'd1);
      t_ready = $realtime;
      @(posedge clk_sys); #1;
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
   endtask

   task automatic ld_write(input logic [24:0] a, input logic [7:0] d, input bit expect_wr);
      if (expect_wr) wr_q.push_back({a[15:0], d});
      ld_wr   = 1'b1;
      ld_addr = a;
      ld_din  = d;
      @(posedge clk_sys); #1;
      ld_wr   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk_sys);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk_sys);
      chk("rst_clr_busy",  clr_busy,  0);
      chk("rst_ld_wait",   ld_wait,   0);
      chk("rst_cpu_ready", cpu_ready, 0);
      chk("rst_ram_we",    ram_we,    0);
      chk("rst_ram_addr",  ram_addr,  0);
      chk("rst_ram_din",   ram_din,   0);
      chk("rst_cpu_dout",  cpu_dout,  0);
      @(posedge clk_sys); #1;

      // Basic CPU write / read
      cpu_access(1'b1, 16'h1234, 8'hA5, 8'h00, 1'b0, lat);
      chk("wr_latency", lat, 2);
      cpu_access(1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, lat);
      chk("rd_latency", lat, 3);
      @(negedge clk_sys);
      chk("cpu_dout_hold", cpu_dout, 8'hA5);
      @(posedge clk_sys); #1;
      cpu_access(1'b0, 16'h2000, 8'h00, 8'h5A, 1'b0, lat);

      // Clear sweep with a stalled CPU read and an ignored second start
      cpu_access(1'b1, 16'h0010, 8'h77, 8'h00, 1'b0, lat);
      cpu_access(1'b0, 16'h0010, 8'h00, 8'h77, 1'b0, lat);
      for (int i = 0; i < 256; i++) wr_q.push_back({i[15:0], 8'h00});
      clr_start = 1'b1;
      @(posedge clk_sys); #1;
      clr_start = 1'b0;
      fork
         begin
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
               @(negedge clk_sys);
               if (clr_busy) found = 1'b1;
            end
            chk("clr_busy_rise", found, 1);
            n = 0;
            while (clr_busy && n < 1000) begin
               n++;
               @(negedge clk_sys);
            end
            t_fall = $realtime;
         end
         begin
            repeat (50) @(posedge clk_sys);
            #1;
            clr_start = 1'b1;
            @(posedge clk_sys); #1;
            clr_start = 1'b0;
            cpu_access(1'b0, 16'h0010, 8'h00, 8'h00, 1'b0, lat2);
         end
      join
      chk("clr_busy_cycles", n, 256);
      chk("rd_waits_for_clear", (t_ready > t_fall), 1);

      // Loader beats a simultaneous CPU read of the same address
      @(posedge clk_sys); #1;
      wr_q.push_back({16'h0100, 8'h3C});
      fork
         begin
            ld_wr   = 1'b1;
            ld_addr = 25'h0000100;
            ld_din  = 8'h3C;
            @(posedge clk_sys); #1;
            ld_wr   = 1'b0;
         end
         cpu_access(1'b0, 16'h0100, 8'h00, 8'h3C, 1'b0, lat3);
         begin
            nw = 0;
            repeat (8) begin
               @(negedge clk_sys);
               if (ld_wait) nw++;
            end
         end
      join
      chk("ld_wait_cycles", nw, 1);
      chk("rd_after_load_latency", lat3, 5);

      // Loader byte outside bank 0 is dropped
      @(posedge clk_sys); #1;
      fork
         ld_write(25'h1_0000, 8'hEE, 1'b0);
         begin
            nw = 0;
            repeat (4) begin
               @(negedge clk_sys);
               if (ld_wait) nw++;
            end
         end
      join
      chk("ld_wait_oob", nw, 0);
      @(posedge clk_sys); #1;
      cpu_access(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, lat);

      // Reset in mid-sweep, with a buffered loader byte pending
      cpu_access(1'b1, 16'h0081, 8'h99, 8'h00, 1'b0, lat);
      cpu_access(1'b1, 16'h007F, 8'h55, 8'h00, 1'b0, lat);
      for (int i = 0; i <= 16'h0080; i++) wr_q.push_back({i[15:0], 8'h00});
      clr_start = 1'b1;
      @(posedge clk_sys); #1;
      clr_start = 1'b0;
      ld_write(25'h0000200, 8'h44, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk_sys);
         if (clr_busy && ram_addr == 16'h0080) found = 1'b1;
      end
      chk("sweep_reached_80", found, 1);
      chk("ld_wait_during_clear", ld_wait, 1);
      reset = 1'b1;
      @(negedge clk_sys);
      chk("clr_busy_after_reset", clr_busy, 0);
      chk("ram_we_after_reset",   ram_we,   0);
      chk("ld_wait_after_reset",  ld_wait,  0);
      chk("sweep_writes_drained", wr_q.size(), 0);
      @(posedge clk_sys); #1;
      reset = 1'b0;
      cpu_access(1'b0, 16'h0081, 8'h00, 8'h99, 1'b0, lat);
      chk("idle_after_reset_latency", lat, 3);
      cpu_access(1'b0, 16'h007F, 8'h00, 8'h00, 1'b0, lat);
      cpu_access(1'b0, 16'h0200, 8'h00, 8'h5A, 1'b0, lat);

`ifdef RAM_WP_EN
      cpu_access(1'b1, 16'hF800, 8'h11, 8'h00, 1'b1, lat);
      chk("wp_wr_latency", lat, 2);
      cpu_access(1'b0, 16'hF800, 8'h00, 8'h5A, 1'b0, lat);
      cpu_access(1'b1, 16'hEFFF, 8'h33, 8'h00, 1'b0, lat);
      cpu_access(1'b0, 16'hEFFF, 8'h00, 8'h33, 1'b0, lat);
      ld_write(25'h000F800, 8'h22, 1'b1);
      cpu_access(1'b0, 16'hF800, 8'h00, 8'h22, 1'b0, lat);
`else
      cpu_access(1'b1, 16'hF800, 8'h11, 8'h00, 1'b0, lat);
      cpu_access(1'b0, 16'hF800, 8'h00, 8'h11, 1'b0, lat);
`endif

      repeat (5) @(negedge clk_sys);
      chk("wr_queue_empty",  wr_q.size(),  0);
      chk("cpu_queue_empty", cpu_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
